// File: rtl/urisc_mem_loader.sv
// URISC 256x8 program memory with byte-stream boot loader, run enable and halt detection.
// Define URISC_MEM_CHECKSUM_EN to require a zero mod-256 sum over the loaded image.
module urisc_mem_loader #(
   parameter int unsigned HALT_CNT = 3
) (
   input  logic       clk_PH1,
   input  logic       rst_n,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   input  logic       ld_last,
   output logic       ld_ready,
   input  logic       clear,
   input  logic       CSMR,
   input  logic       RDMR,
   input  logic       WRITE,
   input  logic [7:0] ADDRESS,
   input  logic [7:0] DATA_OUT,
   output logic [7:0] DATA_IN,
   output logic       RUN,
   output logic       halted,
   output logic       ld_err,
   output logic [8:0] ld_count
);

   localparam int unsigned HCW = $clog2(HALT_CNT + 1);
   localparam logic [HCW-1:0] HC_MAX = HCW'(HALT_CNT);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT, S_ERR} state_t;

   state_t           state_q;
   logic [7:0]       wr_ptr_q;
   logic [8:0]       ld_count_q, cnt_d;
   logic [HCW-1:0]   hc_q, hc_d;
   logic [1:0]       guard_q;
   logic             run_q, ld_ready_q, halted_q, ld_err_q;
   logic             hs, load_we, core_we, hit, last_ok;
   logic [7:0]       mem [256];

`ifdef URISC_MEM_CHECKSUM_EN
   logic [7:0]       sum_q, sum_d;
   assign sum_d   = sum_q + ld_data;
   assign last_ok = (sum_d == 8'h00);
`else
   assign last_ok = 1'b1;
`endif

   assign hs      = ld_valid & ld_ready_q;
   assign load_we = hs & ~clear;
   assign core_we = (state_q == S_RUN) & CSMR & WRITE & ~clear;
   assign hit     = RDMR & CSMR & (ADDRESS == 8'h00);
   assign cnt_d   = ld_count_q + 9'd1;

   // hc is held at zero while the post-entry guard window is open
   always_comb begin
      hc_d = '0;
      if (guard_q == 2'd0 && hit)
         hc_d = (hc_q == HC_MAX) ? hc_q : hc_q + 1'b1;
   end

   always_ff @(posedge clk_PH1) begin
      if (load_we)
         mem[wr_ptr_q] <= ld_data;
      else if (core_we)
         mem[ADDRESS] <= DATA_OUT;
   end

   assign DATA_IN = mem[ADDRESS];

   always_ff @(posedge clk_PH1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOAD;
         wr_ptr_q   <= '0;
         ld_count_q <= '0;
         hc_q       <= '0;
         guard_q    <= '0;
         run_q      <= 1'b0;
         ld_ready_q <= 1'b1;
         halted_q   <= 1'b0;
         ld_err_q   <= 1'b0;
`ifdef URISC_MEM_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else if (clear) begin
         state_q    <= S_LOAD;
         wr_ptr_q   <= '0;
         ld_count_q <= '0;
         hc_q       <= '0;
         guard_q    <= '0;
         run_q      <= 1'b0;
         ld_ready_q <= 1'b1;
         halted_q   <= 1'b0;
         ld_err_q   <= 1'b0;
`ifdef URISC_MEM_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               if (hs) begin
                  wr_ptr_q   <= wr_ptr_q + 8'd1;
                  ld_count_q <= cnt_d;
`ifdef URISC_MEM_CHECKSUM_EN
                  sum_q      <= sum_d;
`endif
                  if (ld_last) begin
                     ld_ready_q <= 1'b0;
                     if (last_ok) begin
                        state_q <= S_RUN;
                        guard_q <= 2'd2;
                        hc_q    <= '0;
                     end else begin
                        state_q  <= S_ERR;
                        ld_err_q <= 1'b1;
                     end
                  end else if (wr_ptr_q == 8'hFF) begin
                     state_q    <= S_ERR;
                     ld_err_q   <= 1'b1;
                     ld_ready_q <= 1'b0;
                  end
               end
            end
            // RUN output rises one edge after the state enters RUN
            S_RUN: begin
               hc_q <= hc_d;
               if (guard_q != 2'd0)
                  guard_q <= guard_q - 2'd1;
               if (hc_d == HC_MAX) begin
                  state_q  <= S_HALT;
                  run_q    <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  run_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ld_ready = ld_ready_q;
   assign RUN      = run_q;
   assign halted   = halted_q;
   assign ld_err   = ld_err_q;
   assign ld_count = ld_count_q;

endmodule

// File: tb/tb_urisc_mem_loader.sv
// Self-checking bench for urisc_mem_loader: behavioural model plus directed literal checks.
module tb_urisc_mem_loader;

   localparam int unsigned HC = 3;
   localparam int ML = 0, MR = 1, MH = 2, ME = 3;

   logic       clk_PH1 = 1'b0;
   logic       rst_n = 1'b0;
   logic       ld_valid = 1'b0, ld_last = 1'b0, clear = 1'b0;
   logic       CSMR = 1'b0, RDMR = 1'b0, WRITE = 1'b0;
   logic [7:0] ld_data = '0, ADDRESS = '0, DATA_OUT = '0;
   logic       ld_ready, RUN, halted, ld_err;
   logic [7:0] DATA_IN;
   logic [8:0] ld_count;

   int checks = 0;
   int errors = 0;

   always #5 clk_PH1 = ~clk_PH1;

   urisc_mem_loader #(.HALT_CNT(HC)) dut (
      .clk_PH1  (clk_PH1),
      .rst_n    (rst_n),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .clear    (clear),
      .CSMR     (CSMR),
      .RDMR     (RDMR),
      .WRITE    (WRITE),
      .ADDRESS  (ADDRESS),
      .DATA_OUT (DATA_OUT),
      .DATA_IN  (DATA_IN),
      .RUN      (RUN),
      .halted   (halted),
      .ld_err   (ld_err),
      .ld_count (ld_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, bytes accepted, edges spent in RUN, consecutive halt polls.
   logic [7:0] mm [256];
   bit         mk [256];
   int         mmode = ML, mcnt = 0, mage = 0, mstreak = 0;
   logic [7:0] msum = '0;
   bit         started = 1'b0;

   always @(posedge clk_PH1) begin
      started = 1'b1;
      if (!rst_n || clear) begin
         mmode = ML; mcnt = 0; msum = '0; mstreak = 0; mage = 0;
      end else if (mmode == ML) begin
         if (ld_valid) begin
            mm[mcnt % 256] = ld_data;
            mk[mcnt % 256] = 1'b1;
            mcnt++;
            msum = msum + ld_data;
            if (ld_last) begin
`ifdef URISC_MEM_CHECKSUM_EN
               mmode = (msum == 8'h00) ? MR : ME;
`else
               mmode = MR;
`endif
               mage = 0; mstreak = 0;
            end else if (mcnt == 256) begin
               mmode = ME;
            end
         end
      end else if (mmode == MR) begin
         if (CSMR && WRITE) begin
            mm[ADDRESS] = DATA_OUT;
            mk[ADDRESS] = 1'b1;
         end
         mage++;
         if (mage <= 2 || !(RDMR && CSMR && ADDRESS == 8'h00)) mstreak = 0;
         else mstreak++;
         if (mstreak == HC) mmode = MH;
      end
   end

   always @(negedge clk_PH1) begin
      if (started) begin
         chk("ld_ready", {31'b0, ld_ready}, {31'b0, mmode == ML});
         chk("RUN",      {31'b0, RUN},      {31'b0, (mmode == MR && mage >= 1)});
         chk("halted",   {31'b0, halted},   {31'b0, mmode == MH});
         chk("ld_err",   {31'b0, ld_err},   {31'b0, mmode == ME});
         chk("ld_count", {23'b0, ld_count}, mcnt);
         if (mk[ADDRESS]) chk("DATA_IN", {24'b0, DATA_IN}, {24'b0, mm[ADDRESS]});
      end
   end

   task automatic tick();
      @(negedge clk_PH1);
      #1;
   endtask

   task automatic idle();
      ld_valid = 1'b0; ld_last = 1'b0; clear = 1'b0;
      CSMR = 1'b0; RDMR = 1'b0; WRITE = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      int unsigned len;
      logic [7:0]  s, d;
      bit          lastb, bias;

      idle();
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
      chk("rst_RUN",      {31'b0, RUN},      32'd0);
      chk("rst_ld_count", {23'b0, ld_count}, 32'd0);
      chk("rst_halted",   {31'b0, halted},   32'd0);
      chk("rst_ld_err",   {31'b0, ld_err},   32'd0);

`ifndef URISC_MEM_CHECKSUM_EN
      send(8'h00, 0); send(8'h05, 0); send(8'h07, 0); send(8'h00, 1);
      chk("load4_count", {23'b0, ld_count}, 32'd4);
      chk("load4_ready", {31'b0, ld_ready}, 32'd0);
      chk("load4_run_lag", {31'b0, RUN}, 32'd0);
      tick();
      chk("load4_run", {31'b0, RUN}, 32'd1);
      ADDRESS = 8'h01; #1;
      chk("load4_rd1", {24'b0, DATA_IN}, 32'h05);
      tick();
      CSMR = 1'b1; WRITE = 1'b1; ADDRESS = 8'h20; DATA_OUT = 8'hA5;
      tick();
      CSMR = 1'b0; WRITE = 1'b0;
      chk("core_wr", {24'b0, DATA_IN}, 32'hA5);
      CSMR = 1'b1; RDMR = 1'b1; ADDRESS = 8'h00;
      tick(); tick();
      ADDRESS = 8'h05;
      tick();
      chk("nohalt_halted", {31'b0, halted}, 32'd0);
      chk("nohalt_run",    {31'b0, RUN},    32'd1);
      ADDRESS = 8'h00;
      tick(); tick();
      chk("halt2_halted", {31'b0, halted}, 32'd0);
      tick();
      chk("halt3_halted", {31'b0, halted}, 32'd1);
      chk("halt3_run",    {31'b0, RUN},    32'd0);
      do_clear();
      chk("clr_ready",  {31'b0, ld_ready}, 32'd1);
      chk("clr_halted", {31'b0, halted},   32'd0);
      CSMR = 1'b1; WRITE = 1'b1; ADDRESS = 8'h20; DATA_OUT = 8'h3C;
      tick();
      idle();
      chk("load_wr_ignored", {24'b0, DATA_IN}, 32'hA5);
      do_clear();
`else
      do_clear();
      send(8'h10, 0); send(8'h20, 0); send(8'hD0, 1);
      chk("cs_ok_err", {31'b0, ld_err}, 32'd0);
      tick();
      chk("cs_ok_run", {31'b0, RUN}, 32'd1);
      ADDRESS = 8'h02; #1;
      chk("cs_ok_rd2", {24'b0, DATA_IN}, 32'hD0);
      do_clear();
      send(8'h10, 0); send(8'h20, 0); send(8'hD1, 1);
      chk("cs_bad_err", {31'b0, ld_err}, 32'd1);
      tick();
      chk("cs_bad_run", {31'b0, RUN}, 32'd0);
      do_clear();
`endif

      for (int i = 0; i < 256; i++) send(8'($urandom), 0);
      chk("ovf_err",   {31'b0, ld_err},   32'd1);
      chk("ovf_ready", {31'b0, ld_ready}, 32'd0);
      chk("ovf_run",   {31'b0, RUN},      32'd0);
      chk("ovf_count", {23'b0, ld_count}, 32'd256);
      do_clear();
      chk("ovf_clr_ready", {31'b0, ld_ready}, 32'd1);
      chk("ovf_clr_count", {23'b0, ld_count}, 32'd0);

      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstmid_count", {23'b0, ld_count}, 32'd0);
      chk("rstmid_ready", {31'b0, ld_ready}, 32'd1);
      ADDRESS = 8'h00; #1; chk("rstmid_rd0", {24'b0, DATA_IN}, 32'hAA);
      ADDRESS = 8'h01; #1; chk("rstmid_rd1", {24'b0, DATA_IN}, 32'hBB);
      ADDRESS = 8'h02; #1; chk("rstmid_rd2", {24'b0, DATA_IN}, 32'hCC);

      for (int ep = 0; ep < 40; ep++) begin
         do_clear();
         len = (ep % 13 == 5) ? 256 : $urandom_range(1, 40);
         s = '0;
         for (int unsigned i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
               ld_valid = 1'b0; ld_last = 1'($urandom); ld_data = 8'($urandom);
               tick();
            end
            lastb = (i == len - 1) && !(len == 256 && ep % 2 == 1);
            d = 8'($urandom);
`ifdef URISC_MEM_CHECKSUM_EN
            if (lastb && ($urandom % 2 == 0)) d = 8'h00 - s;
`endif
            s = s + d;
            send(d, lastb);
         end
         idle();
         repeat (3) tick();
         bias = (ep % 3 == 0);
         repeat (30) begin
            CSMR     = bias ? ($urandom % 6 != 0) : 1'($urandom);
            RDMR     = bias ? ($urandom % 6 != 0) : 1'($urandom);
            WRITE    = ($urandom % 3 == 0);
            ADDRESS  = (bias ? ($urandom % 4 != 0) : ($urandom % 2 == 0)) ? 8'h00 : 8'($urandom);
            DATA_OUT = 8'($urandom);
            ld_valid = 1'($urandom);
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom);
            tick();
         end
         idle();
      end

      idle();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/urisc_mem_loader.md
# urisc_mem_loader

Program memory and boot loader for the URISC core. Holds the 256×8 unified instruction/data memory on the core's memory bus, and fills it from an external byte stream with a valid/ready handshake. Asserts the core's `RUN` once loading completes, and detects program termination (the core parked on address 0).

## Interface
Parameters:
- `HALT_CNT`, default 3: number of consecutive `clk_PH1` posedges with `RDMR`=1 and `ADDRESS`=0 that declare halt.

Ports:
- `clk_PH1` input 1: sole clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ld_valid` input 1: loader byte valid.
- `ld_data` input 8: loader byte.
- `ld_last` input 1: qualifies the final byte of the image.
- `ld_ready` output 1: loader may transfer.
- `clear` input 1: synchronous return to LOAD. Memory contents are retained.
- `CSMR` input 1: core chip select.
- `RDMR` input 1: core read strobe.
- `WRITE` input 1: core write strobe.
- `ADDRESS` input 8: core address.
- `DATA_OUT` input 8: core write data.
- `DATA_IN` output 8: read data to core.
- `RUN` output 1: core run enable.
- `halted` output 1: program finished.
- `ld_err` output 1: load error (overflow, or checksum when enabled).
- `ld_count` output 9: bytes accepted in the current load.

## Operation
- Memory: 256×8.
  - Asynchronous read: `DATA_IN = mem[ADDRESS]` at all times.
  - Synchronous write on the `clk_PH1` posedge.
  - Not reset; contents are undefined until loaded.
- FSM states: LOAD, RUN, HALT, ERR. Reset state is LOAD.
- LOAD:
  - `ld_ready`=1 and `RUN`=0. Core bus writes are ignored.
  - On `ld_valid & ld_ready`, write `ld_data` to `mem[wr_ptr]`, then increment `wr_ptr` and `ld_count`. `wr_ptr` starts at 0.
  - If the accepted byte has `ld_last`=1, go to RUN.
  - If the 256th byte is accepted without `ld_last`, go to ERR. That byte is still written.
  - A `ld_last` on the 256th byte is legal.
- RUN:
  - `RUN`=1, `ld_ready`=0.
  - A core write occurs when `CSMR & WRITE`: `mem[ADDRESS] <= DATA_OUT`.
  - Halt counter `hc`:
    - increments when `RDMR & CSMR & ADDRESS==0`;
    - otherwise clears to 0;
    - saturates at `HALT_CNT`.
  - When `hc` reaches `HALT_CNT`, go to HALT.
  - `hc` is forced to 0 for the first 2 cycles after entering RUN.
- HALT: `RUN`=0, `halted`=1, `ld_ready`=0. Core writes are ignored.
- ERR: `RUN`=0, `ld_err`=1, `ld_ready`=0.
- `clear`=1 from any state:
  - next state is LOAD;
  - `wr_ptr`, `ld_count`, `hc`, `halted` and `ld_err` are cleared;
  - `clear` overrides a same-cycle handshake, so the byte is not written.
- `ld_data` is sampled only during an accepted handshake. `ld_last` without `ld_valid` is ignored.

## Timing
- Reset values: `RUN`=0, `ld_ready`=1, `halted`=0, `ld_err`=0, `ld_count`=0. `DATA_IN` follows memory.
- Load write latency: a byte accepted at edge k is readable on `DATA_IN` after edge k.
- RUN rises at edge k+1 when the last byte is accepted at edge k (registered output).
- Core read is combinational. Data must settle within the half cycle between the core's `ADDRESS` update on the falling edge and its MDR capture on the rising edge.
- Core write: data is visible on `DATA_IN` one cycle after the edge that samples `WRITE`.
- Halt: with `HALT_CNT`=3 and `ADDRESS`=0 with `RDMR`=1 held from edge j, HALT is entered at edge j+2 and `RUN`=0 after it.
- Reset mid-load: returns to LOAD with `ld_count`=0. Memory keeps partially loaded bytes.

## Configuration
- `URISC_MEM_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) covers all accepted bytes, including the `ld_last` byte.
  - On `ld_last`, a sum of 0 goes to RUN; any nonzero sum goes to ERR.
  - The checksum byte is still written to memory.
- Not defined: no sum logic. The `ld_last` byte is ordinary data and always goes to RUN.

## Test plan
- Load bytes 0x00, 0x05, 0x07, 0x00 with `ld_last` on the 4th (checksum disabled) -> `ld_count`=4, `RUN`=1 one cycle later, and `ADDRESS`=1 gives `DATA_IN`=0x05.
- In RUN, core write with `ADDRESS`=0x20, `DATA_OUT`=0xA5, `WRITE`=1 -> next cycle, `ADDRESS`=0x20 reads 0xA5. The same write in LOAD leaves memory unchanged.
- Stream 256 bytes without `ld_last` -> `ld_err`=1, `ld_ready`=0, `RUN`=0. Pulsing `clear` then gives `ld_ready`=1 and `ld_count`=0.
- In RUN, `RDMR`=1 with `ADDRESS`=0 for 2 cycles, then `ADDRESS`=5 -> no halt. Holding `ADDRESS`=0 for 3 cycles -> `halted`=1, `RUN`=0.
- Checksum enabled: stream 0x10, 0x20, 0xD0(last) -> RUN. Stream 0x10, 0x20, 0xD1(last) -> ERR.
- Assert `rst_n`=0 mid-load after 3 bytes, then release -> LOAD, `ld_count`=0, `ld_ready`=1. Bytes at addresses 0–2 remain readable.
